sram_1rwnr_param: RTL and testbench

Parametrised behavioural SRAM with one read/write port (port 0) and NUM_RPORTS read-only ports, all on a single clock. It is the next generation of the 1rw1r macro model. It adds:
- a per-byte write mask;
- a configurable read latency;
- a defined read-during-write collision policy;
- valid strobes on every read port.

It is the storage primitive for the multi-ported memory wrappers, and simulation models are built on it.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_rd_port.sv | 102 ++++++++++
 rtl/sram_1rwnr_param.sv | 119 +++++++++++
 tb/tb_sram_1rwnr_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the sram_1rwnr_param family.
//   WRITE_FIRST_NEW / WRITE_FIRST_OLD : collision policy encodings.
//   byte_merge : overlays the masked bytes of a new word onto an old word.
//   slice_lo   : low bit index of slice idx in a packed bus of width-bit slices.
package sram_pkg;

  localparam int WRITE_FIRST_OLD = 0;
  localparam int WRITE_FIRST_NEW = 1;

  // Widest word byte_merge supports; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int MERGE_MAX_W = 512;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_MAX_W/8; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sram_rd_port.sv
// One read channel of the SRAM model: range check, collision detect against
// the write port, write-first/read-first data select and a 1- or 2-stage
// output pipeline with valid and collision pulses.
//   clk0, rst_n : clock, asynchronous active-low reset
//   rd_en       : read request this cycle (active high)
//   rd_addr     : read address
//   mem_word    : current array contents at rd_addr (pre-write)
//   wr_en       : write port active this cycle (active high)
//   wr_addr, wr_data, wr_mask : write port address, data, byte mask
//   dout, rvalid, coll : read data, one-cycle valid, one-cycle collision flag
module sram_rd_port
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                    clk0,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_word,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid,
  output logic                    coll
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic                  in_range;
  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_data;

  assign in_range = ({1'b0, rd_addr} < DEPTH_L);
  // A zero-mask write changes nothing, so it is not a collision; out-of-range
  // reads never collide because out-of-range writes are dropped.
  assign hit      = rd_en & in_range & wr_en & (|wr_mask) & (rd_addr == wr_addr);
  assign merged   = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(mem_word),
                                           MERGE_MAX_W'(wr_data),
                                           (MERGE_MAX_W/8)'(wr_mask)));

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = (hit && (WRITE_FIRST == WRITE_FIRST_NEW)) ? merged : mem_word;
    end
  end

  // ---- stage p0: sampled at the request edge ----
  logic                  vld_p0;
  logic                  coll_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      coll_p0 <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0  <= rd_en;
      coll_p0 <= hit;
      if (rd_en) data_p0 <= rd_data;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // ---- stage p1: extra output register ----
      logic                  vld_p1;
      logic                  coll_p1;
      logic [DATA_WIDTH-1:0] data_p1;

      always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          coll_p1 <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1  <= vld_p0;
          coll_p1 <= coll_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign dout   = data_p1;
      assign rvalid = vld_p1;
      assign coll   = coll_p1;
    end else begin : g_lat1
      assign dout   = data_p0;
      assign rvalid = vld_p0;
      assign coll   = coll_p0;
    end
  endgenerate

endmodule

// File: rtl/sram_1rwnr_param.sv
// Behavioural SRAM: one read/write port (port 0) plus NUM_RPORTS read-only
// ports on a single clock, byte write mask, 1/2-cycle read latency,
// selectable read-during-write policy and per-port valid/collision strobes.
//   clk0, rst_n           : clock, asynchronous active-low reset
//   csb0, web0            : port 0 chip select / write enable (active low)
//   wmask0, addr0, din0   : port 0 byte mask, address, write data
//   dout0, rvalid0        : port 0 read data and valid
//   csb_r, addr_r         : read port chip selects (active low), packed addresses
//   dout_r, rvalid_r      : packed read data, per-port valid
//   coll_r                : per-port read/write collision flag
module sram_1rwnr_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int NUM_RPORTS   = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                             clk0,
  input  logic                             rst_n,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/8-1:0]          wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             rvalid0,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            rvalid_r,
  output logic [NUM_RPORTS-1:0]            coll_r
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_act;
  logic                  rd0_act;
  logic                  addr0_ok;
  logic [DATA_WIDTH-1:0] word0;
  logic                  coll0_unused;

  assign wr_act   = ~csb0 & ~web0;
  assign rd0_act  = ~csb0 &  web0;
  assign addr0_ok = ({1'b0, addr0} < DEPTH_L);
  assign word0    = addr0_ok ? mem[addr0] : '0;

  // Array is deliberately not reset so contents survive rst_n pulses.
  always_ff @(posedge clk0) begin
    if (wr_act && addr0_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end
    end
  end

  // Port 0 reads and writes are mutually exclusive, so its read channel can
  // never see a collision; the write side is tied off.
  sram_rd_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RAM_DEPTH    (RAM_DEPTH),
    .READ_LATENCY (READ_LATENCY),
    .WRITE_FIRST  (WRITE_FIRST)
  ) u_port0 (
    .clk0     (clk0),
    .rst_n    (rst_n),
    .rd_en    (rd0_act),
    .rd_addr  (addr0),
    .mem_word (word0),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_data  ('0),
    .wr_mask  ('0),
    .dout     (dout0),
    .rvalid   (rvalid0),
    .coll     (coll0_unused)
  );

  generate
    for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_rd
      localparam int LO_A = slice_lo(i, ADDR_WIDTH);
      localparam int LO_D = slice_lo(i, DATA_WIDTH);

      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] w;

      assign a = addr_r[LO_A +: ADDR_WIDTH];
      assign w = ({1'b0, a} < DEPTH_L) ? mem[a] : '0;

      sram_rd_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RAM_DEPTH    (RAM_DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .WRITE_FIRST  (WRITE_FIRST)
      ) u_port (
        .clk0     (clk0),
        .rst_n    (rst_n),
        .rd_en    (~csb_r[i]),
        .rd_addr  (a),
        .mem_word (w),
        .wr_en    (wr_act),
        .wr_addr  (addr0),
        .wr_data  (din0),
        .wr_mask  (wmask0),
        .dout     (dout_r[LO_D +: DATA_WIDTH]),
        .rvalid   (rvalid_r[i]),
        .coll     (coll_r[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rwnr_param.sv
// Directed bench: three instances share one stimulus stream.
//   u_a : write-first, latency 1, depth 1000
//   u_b : read-first,  latency 1, depth 1000
//   u_c : write-first, latency 2, depth 1000
module tb_sram_1rwnr_param;

  logic        clk0;
  logic        rst_n;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [1:0]  csb_r;
  logic [19:0] addr_r;

  logic [31:0] a_dout0, b_dout0, c_dout0;
  logic        a_rvalid0, b_rvalid0, c_rvalid0;
  logic [63:0] a_dout_r, b_dout_r, c_dout_r;
  logic [1:0]  a_rvalid_r, b_rvalid_r, c_rvalid_r;
  logic [1:0]  a_coll_r, b_coll_r, c_coll_r;

  int tests = 0;
  int fails = 0;

  sram_1rwnr_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(1000), .NUM_RPORTS(2),
                     .READ_LATENCY(1), .WRITE_FIRST(1)) u_a (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_dout0), .rvalid0(a_rvalid0), .csb_r(csb_r), .addr_r(addr_r),
    .dout_r(a_dout_r), .rvalid_r(a_rvalid_r), .coll_r(a_coll_r));

  sram_1rwnr_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(1000), .NUM_RPORTS(2),
                     .READ_LATENCY(1), .WRITE_FIRST(0)) u_b (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_dout0), .rvalid0(b_rvalid0), .csb_r(csb_r), .addr_r(addr_r),
    .dout_r(b_dout_r), .rvalid_r(b_rvalid_r), .coll_r(b_coll_r));

  sram_1rwnr_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(1000), .NUM_RPORTS(2),
                     .READ_LATENCY(2), .WRITE_FIRST(1)) u_c (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(c_dout0), .rvalid0(c_rvalid0), .csb_r(csb_r), .addr_r(addr_r),
    .dout_r(c_dout_r), .rvalid_r(c_rvalid_r), .coll_r(c_coll_r));

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = 4'h0;
    csb_r  = 2'b11;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
  endtask

  initial begin
    idle();
    rst_n  = 1'b0;
    addr0  = '0;
    din0   = '0;
    addr_r = '0;
    tick();
    tick();
    check("rst_a_dout_r",   64'(a_dout_r), 64'd0);
    check("rst_a_flags",    64'({a_rvalid0, a_rvalid_r, a_coll_r}), 64'd0);
    check("rst_a_dout0",    64'(a_dout0), 64'd0);
    check("rst_c_dout_r",   64'(c_dout_r), 64'd0);
    rst_n = 1'b1;

    // Masked write then read on port 1
    wr(10'd5, 32'hAABBCCDD, 4'hF);
    tick();
    wr(10'd5, 32'h11223344, 4'h5);
    tick();
    check("wr_no_rvalid0",  64'(a_rvalid0), 64'd0);
    check("wr_dout0_hold",  64'(a_dout0), 64'd0);
    idle();
    csb_r  = 2'b01;
    addr_r = {10'd5, 10'd0};
    tick();
    check("mask_dout_r1",   64'(a_dout_r[63:32]), 64'hAA22CC44);
    check("mask_rvalid",    64'(a_rvalid_r), 64'd2);
    check("mask_coll",      64'(a_coll_r), 64'd0);
    idle();
    tick();
    check("pulse_rvalid",   64'(a_rvalid_r), 64'd0);
    check("hold_dout_r1",   64'(a_dout_r[63:32]), 64'hAA22CC44);

    // Collision write-first / read-first
    wr(10'd7, 32'h00000000, 4'hF);
    tick();
    wr(10'd7, 32'hDEADBEEF, 4'h3);
    csb_r  = 2'b10;
    addr_r = {10'd0, 10'd7};
    tick();
    check("wf_dout_r0",     64'(a_dout_r[31:0]), 64'h0000BEEF);
    check("wf_coll",        64'(a_coll_r), 64'd1);
    check("wf_rvalid",      64'(a_rvalid_r), 64'd1);
    check("rf_dout_r0",     64'(b_dout_r[31:0]), 64'h00000000);
    check("rf_coll",        64'(b_coll_r), 64'd1);
    idle();
    csb_r = 2'b10;
    tick();
    check("rf_next_dout",   64'(b_dout_r[31:0]), 64'h0000BEEF);
    check("rf_next_coll",   64'(b_coll_r), 64'd0);
    check("rf_next_rvalid", 64'(b_rvalid_r), 64'd1);
    idle();
    tick();
    check("wf_coll_pulse",  64'(a_coll_r), 64'd0);

    // Out-of-range write + read at 1010 in the same edge
    wr(10'd1010, 32'hFFFFFFFF, 4'hF);
    csb_r  = 2'b10;
    addr_r = {10'd0, 10'd1010};
    tick();
    check("oor_dout",       64'(a_dout_r[31:0]), 64'd0);
    check("oor_rvalid",     64'(a_rvalid_r), 64'd1);
    check("oor_coll",       64'(a_coll_r), 64'd0);
    // Zero-mask write is a no-op
    idle();
    wr(10'd5, 32'h00000000, 4'h0);
    tick();
    // Duplicate reads on both ports plus a port 0 read
    idle();
    csb0   = 1'b0;
    web0   = 1'b1;
    addr0  = 10'd5;
    csb_r  = 2'b00;
    addr_r = {10'd5, 10'd5};
    tick();
    check("dup_dout_r",     a_dout_r, 64'hAA22CC44_AA22CC44);
    check("dup_rvalid",     64'(a_rvalid_r), 64'd3);
    check("p0_dout0",       64'(a_dout0), 64'hAA22CC44);
    check("p0_rvalid0",     64'(a_rvalid0), 64'd1);
    idle();
    csb_r  = 2'b10;
    addr_r = {10'd0, 10'd1010};
    tick();
    check("oor_reread",     64'(a_dout_r[31:0]), 64'd0);
    idle();
    tick();
    check("p0_pulse",       64'(a_rvalid0), 64'd0);

    // Pipelined reads at latency 2
    wr(10'd1, 32'h11111111, 4'hF);
    tick();
    wr(10'd2, 32'h22222222, 4'hF);
    tick();
    wr(10'd3, 32'h33333333, 4'hF);
    tick();
    idle();
    csb_r  = 2'b10;
    addr_r = {10'd0, 10'd1};
    tick();
    check("l2_rvalid_n",    64'(c_rvalid_r), 64'd0);
    addr_r = {10'd0, 10'd2};
    tick();
    check("l2_rvalid_1",    64'(c_rvalid_r), 64'd1);
    check("l2_dout_1",      64'(c_dout_r[31:0]), 64'h11111111);
    addr_r = {10'd0, 10'd3};
    tick();
    check("l2_rvalid_2",    64'(c_rvalid_r), 64'd1);
    check("l2_dout_2",      64'(c_dout_r[31:0]), 64'h22222222);
    idle();
    tick();
    check("l2_rvalid_3",    64'(c_rvalid_r), 64'd1);
    check("l2_dout_3",      64'(c_dout_r[31:0]), 64'h33333333);
    tick();
    check("l2_rvalid_end",  64'(c_rvalid_r), 64'd0);

    // Reset mid-operation with a read in flight
    wr(10'd9, 32'h12345678, 4'hF);
    csb_r  = 2'b10;
    addr_r = {10'd0, 10'd1};
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("mrst_dout_r",    c_dout_r, 64'd0);
    check("mrst_flags",     64'({c_rvalid0, c_rvalid_r, c_coll_r}), 64'd0);
    check("mrst_dout0",     64'(c_dout0), 64'd0);
    tick();
    check("mrst_rvalid_a",  64'(c_rvalid_r), 64'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_rvalid_b",  64'(c_rvalid_r), 64'd0);
    csb_r  = 2'b00;
    addr_r = {10'd9, 10'd5};
    tick();
    idle();
    check("post_rvalid_n",  64'(c_rvalid_r), 64'd0);
    tick();
    check("post_rvalid",    64'(c_rvalid_r), 64'd3);
    check("post_dout_r",    c_dout_r, 64'h12345678_AA22CC44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
